piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter. Accepts a WIDTH-bit word through a

---
 rtl/piso_serializer.sv | 66 ++++++
 tb/tb_piso_serializer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word over a valid/ready
// handshake and emits it one bit per enabled clock with frame qualifiers.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pdata_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    idx;
  logic             busy;
  logic             at_last;
  logic             accept;

  assign busy    = (state == SHIFT);
  assign at_last = busy && (cnt == LAST_CNT);

  // A new word may be taken in the same edge that retires the last bit.
  assign load_ready = !busy || (at_last && shift_en);
  assign accept     = load_valid && load_ready;

  assign idx = LSB_FIRST ? cnt : (LAST_CNT - cnt);

  // Outputs are decoded from registered state only, so a stall holds them.
  assign sout        = busy && shreg[idx];
  assign sout_valid  = busy;
  assign frame_start = busy && (cnt == '0);
  assign last        = at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else if (accept) begin
      state <= SHIFT;
      cnt   <= '0;
      shreg <= pdata_in;
    end else if (busy && shift_en) begin
      if (cnt == LAST_CNT) begin
        state <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: LSB-first and MSB-first serializers share stimulus and
// are checked by a scoreboard fed from a bit-count reference model.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pdata_in;
  logic         load_valid;
  logic         shift_en;

  logic readyL, soutL, validL, fsL, lastL;
  logic readyM, soutM, validM, fsM, lastM;

  int nChecks = 0;
  int nFails  = 0;
  bit armed   = 1'b0;

  // Reference model: bits still owed for the current word, plus expected
  // {sout, frame_start, last} per bit for each bit order.
  int         rem = 0;
  logic       mReady;
  logic [2:0] qL[$];
  logic [2:0] qM[$];

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .pdata_in(pdata_in), .load_valid(load_valid),
    .load_ready(readyL), .shift_en(shift_en), .sout(soutL),
    .sout_valid(validL), .frame_start(fsL), .last(lastL)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .pdata_in(pdata_in), .load_valid(load_valid),
    .load_ready(readyM), .shift_en(shift_en), .sout(soutM),
    .sout_valid(validM), .frame_start(fsM), .last(lastM)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic se, input logic r);
    pdata_in   = d;
    load_valid = v;
    shift_en   = se;
    reset      = r;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    mReady = (rem == 0) || (rem == 1 && shift_en);
    if (reset) begin
      rem = 0;
      qL.delete();
      qM.delete();
    end else begin
      if (rem > 0 && shift_en) rem = rem - 1;
      if (load_valid && mReady) begin
        for (int i = 0; i < W; i++) begin
          qL.push_back({logic'((pdata_in >> i) & 1), logic'(i == 0), logic'(i == W - 1)});
          qM.push_back({logic'((pdata_in >> (W - 1 - i)) & 1), logic'(i == 0), logic'(i == W - 1)});
        end
        rem = W;
      end
    end
  end

  // Monitor: compare presented bits with the queue head, pop on consume.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("no_x", {2'b00, $isunknown({readyL, soutL, validL, fsL, lastL,
                                              readyM, soutM, validM, fsM, lastM})}, 3'b000);
      checkOutput("load_ready_lsb", {2'b00, readyL}, {2'b00, (rem == 0) || (rem == 1 && shift_en)});
      checkOutput("load_ready_msb", {2'b00, readyM}, {2'b00, (rem == 0) || (rem == 1 && shift_en)});
      checkOutput("sout_valid_lsb", {2'b00, validL}, {2'b00, rem > 0});
      checkOutput("sout_valid_msb", {2'b00, validM}, {2'b00, rem > 0});
      if (validL) begin
        if (qL.size() == 0) checkOutput("lsb_unexpected_bit", 3'b001, 3'b000);
        else begin
          checkOutput("lsb_bit", {soutL, fsL, lastL}, qL[0]);
          if (shift_en) void'(qL.pop_front());
        end
      end else begin
        checkOutput("lsb_idle_outputs", {soutL, fsL, lastL}, 3'b000);
      end
      if (validM) begin
        if (qM.size() == 0) checkOutput("msb_unexpected_bit", 3'b001, 3'b000);
        else begin
          checkOutput("msb_bit", {soutM, fsM, lastM}, qM[0]);
          if (shift_en) void'(qM.pop_front());
        end
      end else begin
        checkOutput("msb_idle_outputs", {soutM, fsM, lastM}, 3'b000);
      end
    end
  end

  initial begin
    reset = 1'b1; load_valid = 1'b0; shift_en = 1'b0; pdata_in = '0;
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    applyStimulus('x, 1'b0, 1'b0, 1'b1);
    armed = 1'b1;
    applyStimulus('x, 1'b0, 1'b1, 1'b0);

    // Single word
    applyStimulus(4'b0110, 1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus('x, 1'b0, 1'b1, 1'b0);

    // Back-to-back: 9 is held until it is taken on the last bit of 6
    applyStimulus(4'h6, 1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(4'h9, 1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus('x, 1'b0, 1'b1, 1'b0);

    // Stall on bit 1
    applyStimulus(4'b0110, 1'b1, 1'b1, 1'b0);
    applyStimulus('x, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus('x, 1'b0, 1'b0, 1'b0);
    repeat (5) applyStimulus('x, 1'b0, 1'b1, 1'b0);

    // MSB-first pattern (both instances see it)
    applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus('x, 1'b0, 1'b1, 1'b0);

    // Reset mid-word at bit 2
    applyStimulus(4'hF, 1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b1);
    repeat (3) applyStimulus('x, 1'b0, 1'b1, 1'b0);

    // Busy ignore: A offered during bit 1 of 5
    applyStimulus(4'h5, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'hA, 1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus('x, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with stalls and occasional resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(W'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
    end

    repeat (8) applyStimulus('x, 1'b0, 1'b1, 1'b0);
    checkOutput("drain_lsb", {2'b00, qL.size() != 0}, 3'b000);
    checkOutput("drain_msb", {2'b00, qM.size() != 0}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
